// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-side bundle for alu_arbiter.
// slave = arbiter side, master = client/ALU side.
interface alu_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [OP_W-1:0]   req0_op_i;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [OP_W-1:0]   req1_op_i;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;
  logic              rsp0_valid_o;
  logic              rsp0_ready_i;
  logic [DATA_W-1:0] rsp0_result_o;
  logic              rsp0_err_o;
  logic              rsp1_valid_o;
  logic              rsp1_ready_i;
  logic [DATA_W-1:0] rsp1_result_o;
  logic              rsp1_err_o;
  logic [OP_W-1:0]   alu_ctrl_o;
  logic [DATA_W-1:0] alu_data0_o;
  logic [DATA_W-1:0] alu_data1_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              busy_o;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  rsp0_ready_i, rsp1_ready_i, alu_result_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_result_o, rsp0_err_o,
    output rsp1_valid_o, rsp1_result_o, rsp1_err_o,
    output alu_ctrl_o, alu_data0_o, alu_data1_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output rsp0_ready_i, rsp1_ready_i, alu_result_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_result_o, rsp0_err_o,
    input  rsp1_valid_o, rsp1_result_o, rsp1_err_o,
    input  alu_ctrl_o, alu_data0_o, alu_data1_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two
// requesters, with registered issue and error flagging.
module alu_arbiter #(
  parameter int DATA_W       = 8,
  parameter int OP_W         = 3,
  parameter int ISSUE_CYCLES = 1
) (
  input logic          clk_i,
  input logic          rst_ni,
  alu_arbiter_if.slave bus
);
  localparam int CNT_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES + 1) : 1;
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(4);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              grant0, grant1;
  logic              rsp_done;
  logic              cap_err;
  logic              v0, v1;

  assign v0 = bus.req0_valid_i;
  assign v1 = bus.req1_valid_i;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        (v0 && !v1): grant0 = 1'b1;
        (!v0 && v1): grant1 = 1'b1;
        (v0 && v1): begin
          grant0 = ~prio_q;
          grant1 = prio_q;
        end
        default: ;
      endcase
    end
  end

  // Error is judged on the operands actually presented to the ALU.
  assign cap_err = (ctrl_q > OP_MOD) ||
                   (((ctrl_q == OP_DIV) || (ctrl_q == OP_MOD)) &&
                    (data1_q == '0));

  assign rsp_done = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    data0_d = data0_q;
    data1_d = data1_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          ctrl_d  = grant1 ? bus.req1_op_i : bus.req0_op_i;
          data0_d = grant1 ? bus.req1_a_i  : bus.req0_a_i;
          data1_d = grant1 ? bus.req1_b_i  : bus.req0_b_i;
          owner_d = grant1;
          cnt_d   = CNT_W'(ISSUE_CYCLES - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          err_d   = cap_err;
          res_d   = cap_err ? '0 : bus.alu_result_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_done) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.req0_ready_o  = grant0;
  assign bus.req1_ready_o  = grant1;
  assign bus.rsp0_valid_o  = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid_o  = (state_q == RESP) && owner_q;
  assign bus.rsp0_result_o = bus.rsp0_valid_o ? res_q : '0;
  assign bus.rsp1_result_o = bus.rsp1_valid_o ? res_q : '0;
  assign bus.rsp0_err_o    = bus.rsp0_valid_o && err_q;
  assign bus.rsp1_err_o    = bus.rsp1_valid_o && err_q;
  assign bus.alu_ctrl_o    = ctrl_q;
  assign bus.alu_data0_o   = data0_q;
  assign bus.alu_data1_o   = data1_q;
  assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU
// standing in for the real combinational unit.
module tb_alu_arbiter;
  logic clk_i;
  logic rst_ni;
  int   tests;
  int   fails;
  logic [7:0] alu_res;

  alu_arbiter_if #(.DATA_W(8), .OP_W(3)) bus ();

  alu_arbiter #(
    .DATA_W(8),
    .OP_W(3),
    .ISSUE_CYCLES(1)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    alu_res = 8'd0;
    case (bus.alu_ctrl_o)
      3'b000: alu_res = bus.alu_data0_o + bus.alu_data1_o;
      3'b001: alu_res = bus.alu_data0_o - bus.alu_data1_o;
      3'b010: alu_res = bus.alu_data0_o * bus.alu_data1_o;
      3'b011: alu_res = (bus.alu_data1_o == 8'd0) ? 8'hFF
                        : bus.alu_data0_o / bus.alu_data1_o;
      3'b100: alu_res = (bus.alu_data1_o == 8'd0) ? bus.alu_data0_o
                        : bus.alu_data0_o % bus.alu_data1_o;
      default: alu_res = 8'hA5;
    endcase
  end
  assign bus.alu_result_i = alu_res;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid_i = 1'b0;
    bus.req0_op_i    = 3'd0;
    bus.req0_a_i     = 8'd0;
    bus.req0_b_i     = 8'd0;
    bus.req1_valid_i = 1'b0;
    bus.req1_op_i    = 3'd0;
    bus.req1_a_i     = 8'd0;
    bus.req1_b_i     = 8'd0;
    bus.rsp0_ready_i = 1'b0;
    bus.rsp1_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // Single requester n, response ready held high, ISSUE_CYCLES=1.
  task automatic one_txn(input int n, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ee,
                         input string tag);
    if (n == 0) begin
      bus.req0_valid_i = 1'b1;
      bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
      bus.rsp0_ready_i = 1'b1;
    end else begin
      bus.req1_valid_i = 1'b1;
      bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
      bus.rsp1_ready_i = 1'b1;
    end
    #1;
    chk1({tag, "_ready"}, n == 0 ? bus.req0_ready_o : bus.req1_ready_o, 1'b1);
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    chk1({tag, "_busy_exec"}, bus.busy_o, 1'b1);
    step();
    chk1({tag, "_valid"}, n == 0 ? bus.rsp0_valid_o : bus.rsp1_valid_o, 1'b1);
    chk1({tag, "_other_valid"},
         n == 0 ? bus.rsp1_valid_o : bus.rsp0_valid_o, 1'b0);
    chk8({tag, "_result"},
         n == 0 ? bus.rsp0_result_o : bus.rsp1_result_o, er);
    chk1({tag, "_err"}, n == 0 ? bus.rsp0_err_o : bus.rsp1_err_o, ee);
    step();
    chk1({tag, "_idle_after"}, bus.busy_o, 1'b0);
    bus.rsp0_ready_i = 1'b0;
    bus.rsp1_ready_i = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk8("rst_alu_ctrl", 8'(bus.alu_ctrl_o), 8'd0);
    chk8("rst_alu_data0", bus.alu_data0_o, 8'd0);
    chk1("rst_rsp0_valid", bus.rsp0_valid_o, 1'b0);
    chk1("rst_rsp1_valid", bus.rsp1_valid_o, 1'b0);
    step();
    rst_ni = 1'b1;
    step();

    // 1: simple add
    one_txn(0, 3'b000, 8'd100, 8'd27, 8'd127, 1'b0, "t1");
    chk8("t1_alu_held", bus.alu_data0_o, 8'd100);

    // 2: both valid from reset, alternate grants
    do_reset();
    bus.req0_valid_i = 1'b1;
    bus.req0_op_i = 3'b010; bus.req0_a_i = 8'd12; bus.req0_b_i = 8'd11;
    bus.req1_valid_i = 1'b1;
    bus.req1_op_i = 3'b001; bus.req1_a_i = 8'd5; bus.req1_b_i = 8'd9;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      logic w;
      w = (g % 2 == 1);
      chk1("t2_ready0", bus.req0_ready_o, !w);
      chk1("t2_ready1", bus.req1_ready_o, w);
      step();
      chk1("t2_no_ready_exec", bus.req0_ready_o | bus.req1_ready_o, 1'b0);
      step();
      chk1("t2_rsp0_valid", bus.rsp0_valid_o, !w);
      chk1("t2_rsp1_valid", bus.rsp1_valid_o, w);
      chk8("t2_result", w ? bus.rsp1_result_o : bus.rsp0_result_o,
           w ? 8'hFC : 8'd132);
      step();
    end
    idle_inputs();
    step();

    // 3: divide by zero, then a legal mod
    one_txn(1, 3'b011, 8'd50, 8'd0, 8'd0, 1'b1, "t3_div0");
    one_txn(1, 3'b100, 8'd50, 8'd7, 8'd1, 1'b0, "t3_mod");

    // 4: illegal opcode
    one_txn(0, 3'b111, 8'd3, 8'd4, 8'd0, 1'b1, "t4_illegal");
    step();
    chk1("t4_idle", bus.busy_o, 1'b0);

    // 5: stalled response with a competing request
    bus.req0_valid_i = 1'b1;
    bus.req0_op_i = 3'b000; bus.req0_a_i = 8'd1; bus.req0_b_i = 8'd2;
    #1;
    chk1("t5_ready0", bus.req0_ready_o, 1'b1);
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b1;
    bus.req1_op_i = 3'b000; bus.req1_a_i = 8'd5; bus.req1_b_i = 8'd6;
    bus.rsp1_ready_i = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      chk1("t5_rsp0_valid", bus.rsp0_valid_o, 1'b1);
      chk8("t5_rsp0_result", bus.rsp0_result_o, 8'd3);
      chk1("t5_req1_ready", bus.req1_ready_o, 1'b0);
      chk1("t5_busy", bus.busy_o, 1'b1);
      chk8("t5_alu_data0", bus.alu_data0_o, 8'd1);
      step();
    end
    bus.rsp0_ready_i = 1'b1;
    step();
    bus.rsp0_ready_i = 1'b0;
    #1;
    chk1("t5_rsp0_done", bus.rsp0_valid_o, 1'b0);
    chk1("t5_req1_granted", bus.req1_ready_o, 1'b1);
    step();
    bus.req1_valid_i = 1'b0;
    step();
    chk8("t5_rsp1_result", bus.rsp1_result_o, 8'd11);
    step();
    idle_inputs();

    // 6: reset in EXEC after prio has moved to 1
    one_txn(0, 3'b000, 8'd2, 8'd2, 8'd4, 1'b0, "t6_pre");
    bus.req0_valid_i = 1'b1;
    bus.req0_op_i = 3'b000; bus.req0_a_i = 8'd9; bus.req0_b_i = 8'd9;
    bus.rsp0_ready_i = 1'b1;
    step();
    bus.req0_valid_i = 1'b0;
    chk1("t6_busy_exec", bus.busy_o, 1'b1);
    chk8("t6_alu_data0_exec", bus.alu_data0_o, 8'd9);
    rst_ni = 1'b0;
    #1;
    chk1("t6_rst_busy", bus.busy_o, 1'b0);
    chk8("t6_rst_alu_data0", bus.alu_data0_o, 8'd0);
    chk8("t6_rst_alu_data1", bus.alu_data1_o, 8'd0);
    chk1("t6_rst_rsp0_valid", bus.rsp0_valid_o, 1'b0);
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk1("t6_no_rsp0", bus.rsp0_valid_o, 1'b0);
      chk1("t6_no_busy", bus.busy_o, 1'b0);
    end
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    chk1("t6_grant0", bus.req0_ready_o, 1'b1);
    chk1("t6_no_grant1", bus.req1_ready_o, 1'b0);
    step();
    idle_inputs();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
